// File: rtl/vga_quadrant_painter.sv
//------------------------------------------------------------------------------
// Module      : vga_quadrant_painter
// Description : 640x480@60 VGA timing generator that paints four colour quadrants,
//               sampling the colour inputs once per frame at the frame boundary.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_quadrant_painter #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic [23:0] icolor1,
    input  logic [23:0] icolor2,
    input  logic [23:0] icolor3,
    input  logic [23:0] icolor4,
    output logic [7:0]  ored,
    output logic [7:0]  ogreen,
    output logic [7:0]  oblue,
    output logic        oblank_n,
    output logic        ohsync,
    output logic        ovsync,
    output logic        opix_tick,
    output logic        oframe_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);
    localparam int c_DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(CLK_DIV - 1);
    localparam logic [c_HW-1:0] c_H_LAST    = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_VIS     = c_HW'(H_VISIBLE);
    localparam logic [c_HW-1:0] c_H_HALF    = c_HW'(H_VISIBLE / 2);
    localparam logic [c_HW-1:0] c_HS_START  = c_HW'(H_VISIBLE + H_FRONT);
    localparam logic [c_HW-1:0] c_HS_END    = c_HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST    = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_VIS     = c_VW'(V_VISIBLE);
    localparam logic [c_VW-1:0] c_V_HALF    = c_VW'(V_VISIBLE / 2);
    localparam logic [c_VW-1:0] c_VS_START  = c_VW'(V_VISIBLE + V_FRONT);
    localparam logic [c_VW-1:0] c_VS_END    = c_VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [c_DW-1:0] r_div_cnt_q, w_div_cnt_d;
    logic [c_HW-1:0] r_hcount_q,  w_hcount_d;
    logic [c_VW-1:0] r_vcount_q,  w_vcount_d;
    logic [23:0]     r_col1_q, w_col1_d;
    logic [23:0]     r_col2_q, w_col2_d;
    logic [23:0]     r_col3_q, w_col3_d;
    logic [23:0]     r_col4_q, w_col4_d;
    logic [23:0]     r_rgb_q,  w_rgb_d;
    logic            r_blank_n_q, w_blank_n_d;
    logic            r_hsync_q,   w_hsync_d;
    logic            r_vsync_q,   w_vsync_d;
    logic            r_pix_tick_q, w_pix_tick_d;
    logic            r_frame_start_q, w_frame_start_d;

    logic            w_tick;
    logic            w_visible;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic            w_frame_end;
    logic [23:0]     w_pix_color;

    assign w_tick      = (r_div_cnt_q == c_DIV_LAST);
    assign w_h_wrap    = (r_hcount_q == c_H_LAST);
    assign w_v_wrap    = (r_vcount_q == c_V_LAST);
    assign w_frame_end = w_tick && w_h_wrap && w_v_wrap;
    assign w_visible   = (r_hcount_q < c_H_VIS) && (r_vcount_q < c_V_VIS);

    // Quadrant select; blanking forces black so the DAC sees 0 in the porches.
    always_comb begin
        w_pix_color = 24'h000000;
        if (w_visible) begin
            if (r_vcount_q < c_V_HALF) begin
                w_pix_color = (r_hcount_q < c_H_HALF) ? r_col1_q : r_col2_q;
            end else begin
                w_pix_color = (r_hcount_q < c_H_HALF) ? r_col3_q : r_col4_q;
            end
        end
    end

    always_comb begin
        w_div_cnt_d     = w_tick ? '0 : r_div_cnt_q + 1'b1;
        w_hcount_d      = r_hcount_q;
        w_vcount_d      = r_vcount_q;
        w_rgb_d         = r_rgb_q;
        w_blank_n_d     = r_blank_n_q;
        w_hsync_d       = r_hsync_q;
        w_vsync_d       = r_vsync_q;
        w_col1_d        = r_col1_q;
        w_col2_d        = r_col2_q;
        w_col3_d        = r_col3_q;
        w_col4_d        = r_col4_q;
        w_pix_tick_d    = w_tick;
        w_frame_start_d = w_frame_end;

        if (w_tick) begin
            // Outputs reflect the pre-increment position: one pixel of latency.
            w_rgb_d     = w_pix_color;
            w_blank_n_d = w_visible;
            w_hsync_d   = !((r_hcount_q >= c_HS_START) && (r_hcount_q < c_HS_END));
            w_vsync_d   = !((r_vcount_q >= c_VS_START) && (r_vcount_q < c_VS_END));
            if (w_h_wrap) begin
                w_hcount_d = '0;
                w_vcount_d = w_v_wrap ? '0 : r_vcount_q + 1'b1;
            end else begin
                w_hcount_d = r_hcount_q + 1'b1;
            end
        end

        if (w_frame_end) begin
            w_col1_d = icolor1;
            w_col2_d = icolor2;
            w_col3_d = icolor3;
            w_col4_d = icolor4;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_div_cnt_q     <= '0;
            r_hcount_q      <= '0;
            r_vcount_q      <= '0;
            r_col1_q        <= '0;
            r_col2_q        <= '0;
            r_col3_q        <= '0;
            r_col4_q        <= '0;
            r_rgb_q         <= '0;
            r_blank_n_q     <= 1'b0;
            r_hsync_q       <= 1'b1;
            r_vsync_q       <= 1'b1;
            r_pix_tick_q    <= 1'b0;
            r_frame_start_q <= 1'b0;
        end else begin
            r_div_cnt_q     <= w_div_cnt_d;
            r_hcount_q      <= w_hcount_d;
            r_vcount_q      <= w_vcount_d;
            r_col1_q        <= w_col1_d;
            r_col2_q        <= w_col2_d;
            r_col3_q        <= w_col3_d;
            r_col4_q        <= w_col4_d;
            r_rgb_q         <= w_rgb_d;
            r_blank_n_q     <= w_blank_n_d;
            r_hsync_q       <= w_hsync_d;
            r_vsync_q       <= w_vsync_d;
            r_pix_tick_q    <= w_pix_tick_d;
            r_frame_start_q <= w_frame_start_d;
        end
    end

    assign ored         = r_rgb_q[23:16];
    assign ogreen       = r_rgb_q[15:8];
    assign oblue        = r_rgb_q[7:0];
    assign oblank_n     = r_blank_n_q;
    assign ohsync       = r_hsync_q;
    assign ovsync       = r_vsync_q;
    assign opix_tick    = r_pix_tick_q;
    assign oframe_start = r_frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_quadrant_painter.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_quadrant_painter
// Description : Directed bench for vga_quadrant_painter on a scaled-down raster
//               (24x13 total, 16x8 visible) so whole frames run in a few hundred ticks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_quadrant_painter;

    // Scaled raster: hsync on h=18..20, vsync on v=9..10, quadrant split at h=8, v=4.
    localparam int c_H_TOT = 24;
    localparam int c_V_TOT = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] c1 = 24'h0, c2 = 24'h0, c3 = 24'h0, c4 = 24'h0;
    logic [7:0]  red, green, blue;
    logic        blank_n, hsync, vsync, pix_tick, frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_h;
    int cur_v;

    vga_quadrant_painter #(
        .CLK_DIV   (2),
        .H_VISIBLE (16),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (8),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (2)
    ) dut (
        .iclk         (clk),
        .irst         (rst),
        .icolor1      (c1),
        .icolor2      (c2),
        .icolor3      (c3),
        .icolor4      (c4),
        .ored         (red),
        .ogreen       (green),
        .oblue        (blue),
        .oblank_n     (blank_n),
        .ohsync       (hsync),
        .ovsync       (vsync),
        .opix_tick    (pix_tick),
        .oframe_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (pixel h=%0d v=%0d)", tag, got, exp, cur_h, cur_v);
        end
    endtask

    // Advance to the next presented pixel; bench tracks its position independently.
    task automatic step();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pix_tick && k < 8);
        if (!pix_tick) check("tick_timeout", 32'd0, 32'd1);
        if (cur_h == c_H_TOT - 1) begin
            cur_h = 0;
            cur_v = (cur_v == c_V_TOT - 1) ? 0 : cur_v + 1;
        end else begin
            cur_h = cur_h + 1;
        end
    endtask

    task automatic goto_pix(input int h, input int v);
        int k = 0;
        while (!(cur_h == h && cur_v == v) && k < 2 * c_H_TOT * c_V_TOT) begin
            step();
            k++;
        end
        if (!(cur_h == h && cur_v == v)) check("goto_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, red, green, blue};
    endfunction

    initial begin
        int hs_low, bl_high, hs_first, vs_low, vs_first_v, fs_cnt, fs_h, fs_v;

        c1 = 24'hFF0000; c2 = 24'h00FF00; c3 = 24'h0000FF; c4 = 24'hFFFFFF;
        cur_h = c_H_TOT - 1;
        cur_v = c_V_TOT - 1;

        // Reset held three cycles
        repeat (3) @(negedge clk);
        check("rst_rgb",     rgb(),       32'h0);
        check("rst_blank_n", blank_n,     32'd0);
        check("rst_hsync",   hsync,       32'd1);
        check("rst_vsync",   vsync,       32'd1);
        check("rst_tick",    pix_tick,    32'd0);
        check("rst_fstart",  frame_start, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("tick_1st_edge", pix_tick, 32'd0);
        @(negedge clk);
        check("tick_2nd_edge", pix_tick, 32'd1);
        cur_h = 0;
        cur_v = 0;
        check("p00_blank_n", blank_n, 32'd1);
        check("p00_black",   rgb(),   32'h0);
        check("p00_hsync",   hsync,   32'd1);

        // One full line (line 1)
        goto_pix(23, 0);
        hs_low = 0; bl_high = 0; hs_first = -1;
        for (int i = 0; i < c_H_TOT; i++) begin
            step();
            if (!hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = cur_h;
            end
            if (blank_n) bl_high++;
        end
        check("line_hs_low_cnt", hs_low,   32'd3);
        check("line_hs_first",   hs_first, 32'd18);
        check("line_blank_high", bl_high,  32'd16);
        check("line_end_h",      cur_h,    32'd23);

        // One full frame, starting after line 1
        vs_low = 0; vs_first_v = -1; fs_cnt = 0; fs_h = -1; fs_v = -1;
        for (int i = 0; i < c_H_TOT * c_V_TOT; i++) begin
            step();
            if (!vsync) begin
                vs_low++;
                if (vs_first_v < 0) vs_first_v = cur_v;
            end
            if (frame_start) begin
                fs_cnt++;
                fs_h = cur_h;
                fs_v = cur_v;
            end
        end
        check("frame_vs_low_px", vs_low,     32'd48);
        check("frame_vs_first",  vs_first_v, 32'd9);
        check("frame_fs_count",  fs_cnt,     32'd1);
        check("frame_fs_h",      fs_h,       32'd23);
        check("frame_fs_v",      fs_v,       32'd12);

        // Quadrant colours (latched at the frame end just passed)
        goto_pix(0, 0);
        check("q_tl", rgb(), 32'hFF0000);
        goto_pix(8, 0);
        check("q_tr", rgb(), 32'h00FF00);
        goto_pix(15, 0);
        check("q_tr_edge", rgb(), 32'h00FF00);
        goto_pix(16, 0);
        check("q_hblank", rgb(), 32'h0);
        check("q_hblank_n", blank_n, 32'd0);
        goto_pix(0, 4);
        check("q_bl", rgb(), 32'h0000FF);
        goto_pix(15, 7);
        check("q_br", rgb(), 32'hFFFFFF);
        goto_pix(0, 8);
        check("q_vblank_n", blank_n, 32'd0);

        // Tear-free: change colour mid-frame
        goto_pix(0, 2);
        c1 = 24'h123456;
        goto_pix(0, 3);
        check("tear_old", rgb(), 32'hFF0000);
        goto_pix(0, 0);
        check("tear_new", rgb(), 32'h123456);

        // Reset in the middle of an hsync pulse
        goto_pix(19, 6);
        check("mid_hsync_low", hsync, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_hsync", hsync,   32'd1);
        check("mrst_vsync", vsync,   32'd1);
        check("mrst_rgb",   rgb(),   32'h0);
        check("mrst_blank", blank_n, 32'd0);
        rst = 1'b0;
        cur_h = c_H_TOT - 1;
        cur_v = c_V_TOT - 1;
        step();
        check("mrst_p00_blank_n", blank_n, 32'd1);
        check("mrst_p00_black",   rgb(),   32'h0);
        hs_low = hsync ? 0 : 1;
        for (int i = 1; i < c_H_TOT; i++) begin
            step();
            if (!hsync) hs_low++;
        end
        check("mrst_hs_low_cnt", hs_low, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
